// File: rtl/iob_core_bus_arbiter.sv
// Two-requester arbiter sharing one IOb port between the CPU instruction and data buses.
// Define IOB_CORE_BUS_ARB_RR_EN for round-robin grant; default is fixed priority (dbus over ibus).
module iob_core_bus_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MAX_OUT = 2
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                ibus_avalid_i,
   input  logic [ADDR_W-1:0]   ibus_addr_i,
   output logic                ibus_ready_o,
   output logic                ibus_rvalid_o,
   output logic [DATA_W-1:0]   ibus_rdata_o,
   input  logic                dbus_avalid_i,
   input  logic [ADDR_W-1:0]   dbus_addr_i,
   input  logic [DATA_W-1:0]   dbus_wdata_i,
   input  logic [DATA_W/8-1:0] dbus_wstrb_i,
   output logic                dbus_ready_o,
   output logic                dbus_rvalid_o,
   output logic [DATA_W-1:0]   dbus_rdata_o,
   output logic                m_avalid_o,
   output logic [ADDR_W-1:0]   m_addr_o,
   output logic [DATA_W-1:0]   m_wdata_o,
   output logic [DATA_W/8-1:0] m_wstrb_o,
   input  logic                m_ready_i,
   input  logic                m_rvalid_i,
   input  logic [DATA_W-1:0]   m_rdata_i,
   output logic                busy_o
);

   localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

   typedef enum logic {
      REQ_IBUS = 1'b0,
      REQ_DBUS = 1'b1
   } req_t;

   req_t             id_mem [MAX_OUT];
   req_t             last_grant;
   req_t             grant;
   req_t             head_id;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             full;
   logic             empty;
   logic             grant_valid;
   logic             xfer;
   logic             push;
   logic             pop;
   logic             busy;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (count == CNT_W'(MAX_OUT));
   assign empty = (count == '0);

   always_comb begin
      grant = REQ_DBUS;
`ifdef IOB_CORE_BUS_ARB_RR_EN
      if (ibus_avalid_i && dbus_avalid_i) begin
         grant = (last_grant == REQ_DBUS) ? REQ_IBUS : REQ_DBUS;
      end else if (ibus_avalid_i) begin
         grant = REQ_IBUS;
      end
`else
      if (ibus_avalid_i && !dbus_avalid_i) begin
         grant = REQ_IBUS;
      end
`endif
   end

   assign grant_valid = !full && (ibus_avalid_i || dbus_avalid_i);

   always_comb begin
      m_avalid_o   = 1'b0;
      m_addr_o     = '0;
      m_wdata_o    = '0;
      m_wstrb_o    = '0;
      ibus_ready_o = 1'b0;
      dbus_ready_o = 1'b0;
      if (grant_valid) begin
         m_avalid_o = 1'b1;
         if (grant == REQ_IBUS) begin
            m_addr_o     = ibus_addr_i;
            ibus_ready_o = m_ready_i;
         end else begin
            m_addr_o     = dbus_addr_i;
            m_wdata_o    = dbus_wdata_i;
            m_wstrb_o    = dbus_wstrb_i;
            dbus_ready_o = m_ready_i;
         end
      end
   end

   assign xfer = grant_valid && m_ready_i;
   assign push = xfer && ((grant == REQ_IBUS) || (dbus_wstrb_i == '0));
   assign pop  = m_rvalid_i && !empty;

   assign head_id       = id_mem[rd_ptr];
   assign ibus_rvalid_o = pop && (head_id == REQ_IBUS);
   assign dbus_rvalid_o = pop && (head_id == REQ_DBUS);
   assign ibus_rdata_o  = m_rdata_i;
   assign dbus_rdata_o  = m_rdata_i;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         id_mem[wr_ptr] <= grant;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         busy       <= 1'b0;
         last_grant <= REQ_DBUS;
      end else begin
         count <= count_next;
         busy  <= (count_next != '0);
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         // Only a changed ID needs writing; this keeps last_grant observed in fixed-priority builds.
         if (xfer && (grant != last_grant)) begin
            last_grant <= grant;
         end
      end
   end

   assign busy_o = busy;

endmodule

// File: doc/iob_core_bus_arbiter.md
Name: iob_core_bus_arbiter

Overview:
- Two-requester arbiter that shares one IOb memory port between the CPU wrapper's instruction bus (requester 0) and data bus (requester 1).
- Sits between the VexRiscv wrapper and the SoC's single-port memory or interconnect, for SoCs that expose one port only.
- Grants one request per cycle and tracks outstanding reads in order.
- Routes each returning read response (rvalid/rdata) back to the requester that issued it.

Parameters:
- ADDR_W, 32, address width of slave and master ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAX_OUT, 2, maximum outstanding reads (power of 2, ≥1); depth of the ID FIFO

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous reset, active-low
- ibus_avalid_i  in  1  instruction request valid
- ibus_addr_i  in  ADDR_W  instruction address
- ibus_ready_o  out  1  instruction request accepted this cycle
- ibus_rvalid_o  out  1  instruction read data valid
- ibus_rdata_o  out  DATA_W  instruction read data
- dbus_avalid_i  in  1  data request valid
- dbus_addr_i  in  ADDR_W  data address
- dbus_wdata_i  in  DATA_W  write data
- dbus_wstrb_i  in  DATA_W/8  write strobe; 0 means read
- dbus_ready_o  out  1  data request accepted this cycle
- dbus_rvalid_o  out  1  data read data valid
- dbus_rdata_o  out  DATA_W  data read data
- m_avalid_o  out  1  shared-port request valid
- m_addr_o  out  ADDR_W  shared-port address
- m_wdata_o  out  DATA_W  shared-port write data (0 for ibus)
- m_wstrb_o  out  DATA_W/8  shared-port strobe (0 for ibus)
- m_ready_i  in  1  shared-port request accepted
- m_rvalid_i  in  1  shared-port read data valid
- m_rdata_i  in  DATA_W  shared-port read data
- busy_o  out  1  one or more reads outstanding

Behaviour:
- Clocking: one clock, clk_i. Reset arst_n_i is asynchronous, active-low.
- Reset: ID FIFO empty (count=0, pointers=0); last_grant=1 (dbus).
  - With no requests, all outputs are 0.
- Handshake: a transfer occurs when m_avalid_o & m_ready_i.
  - ready_o is asserted only to the granted requester, and equals m_ready_i.
  - The requester not granted sees ready_o=0 and must hold its request.
- Grant: combinational each cycle.
  - Candidates: requesters with avalid_i=1.
  - If FIFO full (count==MAX_OUT), there is no grant: m_avalid_o=0 and both ready_o=0. Writes are blocked too.
  - Full is computed from the registered count. A pop in the same cycle does not unblock a push.
- Mux: m_addr/m_wdata/m_wstrb come from the granted requester.
  - When there is no grant, these outputs and m_avalid_o are 0.
- Read tracking:
  - Push the granter ID on a transfer that is an ibus request, or a dbus request with wstrb==0.
  - dbus writes (wstrb≠0) push nothing and get no rvalid.
- Response routing:
  - On m_rvalid_i with FIFO non-empty: pop the head. The head ID selects which rvalid_o pulses for 1 cycle.
  - m_rdata_i is broadcast to both rdata_o; rvalid qualifies it.
  - m_rvalid_i with FIFO empty is dropped: no rvalid_o, no state change.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Responses are assumed in order. Pointers wrap modulo MAX_OUT.
- busy_o = (count≠0), registered.
- last_grant updates only on a completed transfer, to the ID of that transfer.
- Reset asserted mid-operation: the FIFO is flushed immediately. Later stray rvalids are dropped per the empty rule.

Optional Feature:
- Macro IOB_CORE_BUS_ARB_RR_EN.
- Defined: round-robin grant. When both requesters are valid, grant the one ≠ last_grant. A single valid requester always wins.
- Undefined: fixed priority, dbus over ibus. last_grant is still maintained but unused.

Test Plan:
- Reset: hold arst_n_i=0 with both avalid=1 → all registers cleared.
  - Release → grant per mode. RR: ibus first. Fixed: dbus.
- Contention: both avalid=1 for 4 cycles, m_ready_i=1, all reads, MAX_OUT=4, responses lag 2 cycles.
  - RR: grant order I,D,I,D.
  - Fixed: D,D,D,D with ibus_ready_o=0.
- Routing: ibus read at addr 0x100, then dbus read at 0x2000.
  - m_rvalid_i returns 0xAAAA then 0x5555.
  - Required: ibus_rvalid_o with 0xAAAA, then dbus_rvalid_o with 0x5555.
- Full: MAX_OUT=2, issue 2 reads with no responses.
  - Third request (read or write) stalls: m_avalid_o=0.
  - Cycle of m_rvalid_i → stall still present that cycle; accepted the next cycle.
- Writes: dbus wstrb=0xF, data 0xDEADBEEF, addr 0x40.
  - m_wstrb_o=0xF, m_wdata_o=0xDEADBEEF. FIFO count unchanged, busy_o stays 0.
  - Following m_rvalid_i is dropped.
- Backpressure: m_ready_i=0 for 3 cycles with dbus avalid held.
  - dbus_ready_o=0, no push, m_addr_o stable.
  - Accepted on the cycle m_ready_i=1.
